i2s_tdm_tx: RTL and testbench

Parametrised serial audio transmitter. It serialises NUM_CH signed PCM words per frame onto a single data line, MSB first. Three framing modes are supported: I2S (one-bit delay), left-justified, and TDM with a one-bit frame-sync pulse. Frames come from a small input FIFO with a valid/ready handshake. The block sits between the audio processing datapath and the codec or DAC pins, and runs entirely in the bit-clock domain.

---
 rtl/i2s_tdm_tx.sv | 183 ++++++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tdm_tx
// Brief    : I2S / left-justified / TDM serial audio transmitter fed by a frame FIFO
// Revision : 1.0
// ============================================================================
module i2s_tdm_tx #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             sclk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [1:0]                       mode,
  input  logic [NUM_CH*DATA_W-1:0]         s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic                             lrclk,
  output logic                             sdata,
  output logic                             underrun,
  input  logic                             clr_underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int c_FRAME      = NUM_CH * SLOT_W;
  localparam int c_FRAME_BITS = NUM_CH * DATA_W;
  localparam int c_POS_W      = (c_FRAME > 1) ? $clog2(c_FRAME) : 1;
  localparam int c_IDX_W      = (c_FRAME_BITS > 1) ? $clog2(c_FRAME_BITS) : 1;
  localparam int c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_LVL_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0]         c_MODE_LJ  = 2'b01;
  localparam logic [1:0]         c_MODE_TDM = 2'b10;
  localparam logic [c_POS_W-1:0] c_POS_LAST = c_POS_W'(c_FRAME - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } t_state;

  t_state                    r_state;
  logic [c_POS_W-1:0]        r_pos;
  logic [c_FRAME_BITS-1:0]   r_frame;
  logic [1:0]                r_mode;

  logic [c_FRAME_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_LVL_W-1:0]        r_level;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_empty;
  logic                      w_frame_end;
  logic                      w_underrun_evt;
  logic                      w_frame_last;
  logic [c_FRAME_BITS-1:0]   w_head;
  logic [c_FRAME_BITS-1:0]   w_next_frame;

  // Pin values {lrclk, sdata} for bit position pos of a frame; prev_bit is the
  // final bit of the preceding frame, shown at pos 0 in the delayed modes.
  function automatic logic [1:0] f_pins(input logic [c_FRAME_BITS-1:0] frame,
                                        input logic [1:0]              md,
                                        input logic [c_POS_W-1:0]      pos,
                                        input logic                    prev_bit);
    int   p;
    int   q;
    int   slot;
    int   b;
    logic lr;
    logic sd;
    p = int'(pos);
    if (md == c_MODE_LJ) begin
      lr = (p < c_FRAME / 2);
      q  = p;
    end else begin
      lr = (md == c_MODE_TDM) ? (p == 0) : (p >= c_FRAME / 2);
      q  = (p == 0) ? c_FRAME - 1 : p - 1;
    end
    slot = q / SLOT_W;
    b    = q % SLOT_W;
    if (md != c_MODE_LJ && p == 0)
      sd = prev_bit;
    else if (b < DATA_W)
      sd = frame[c_IDX_W'(slot * DATA_W + DATA_W - 1 - b)];
    else
      sd = 1'b0;
    return {lr, sd};
  endfunction

  function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] ptr);
    return (ptr == c_PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign s_ready        = (r_level < c_LVL_W'(FIFO_DEPTH));
  assign fifo_level     = r_level;
  assign w_empty        = (r_level == '0);
  assign w_push         = s_valid && s_ready;
  assign w_frame_end    = (r_state == S_RUN) && (r_pos == c_POS_LAST);
  assign w_pop          = en && !w_empty && ((r_state == S_IDLE) || w_frame_end);
  assign w_underrun_evt = en && w_empty && w_frame_end;
  assign w_head         = r_mem[r_rd_ptr];
  assign w_next_frame   = w_pop ? w_head : '0;

  // Last bit of a frame is non-zero only when the slot carries no padding.
  assign w_frame_last = (SLOT_W == DATA_W) ? r_frame[c_FRAME_BITS - DATA_W] : 1'b0;

  always_ff @(negedge sclk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)
        r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_push && !w_pop)
        r_level <= r_level + 1'b1;
      else if (w_pop && !w_push)
        r_level <= r_level - 1'b1;
    end
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pos    <= '0;
      r_frame  <= '0;
      r_mode   <= '0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (w_underrun_evt)
        underrun <= 1'b1;
      else if (clr_underrun)
        underrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          lrclk <= 1'b0;
          sdata <= 1'b0;
          if (w_pop) begin
            r_state        <= S_RUN;
            r_pos          <= '0;
            r_frame        <= w_head;
            r_mode         <= mode;
            {lrclk, sdata} <= f_pins(w_head, mode, '0, 1'b0);
          end
        end
        S_RUN: begin
          if (!w_frame_end) begin
            r_pos          <= r_pos + 1'b1;
            {lrclk, sdata} <= f_pins(r_frame, r_mode, r_pos + 1'b1, 1'b0);
          end else if (!en) begin
            // Delayed modes still owe the final bit of this frame.
            r_state <= S_IDLE;
            r_pos   <= '0;
            lrclk   <= 1'b0;
            sdata   <= (r_mode == c_MODE_LJ) ? 1'b0 : w_frame_last;
          end else begin
            r_pos          <= '0;
            r_frame        <= w_next_frame;
            r_mode         <= mode;
            {lrclk, sdata} <= f_pins(w_next_frame, mode, '0, w_frame_last);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tdm_tx
// Brief    : Scoreboard bench: stereo I2S/LJ instance plus 8-slot TDM instance
// Revision : 1.0
// ============================================================================
module tb_i2s_tdm_tx;

  localparam int         c_NA  = 64;
  localparam int         c_NB  = 256;
  localparam logic [1:0] c_I2S = 2'b00;
  localparam logic [1:0] c_LJ  = 2'b01;
  localparam logic [1:0] c_TDM = 2'b10;

  logic         sclk = 1'b1;
  logic         rst_n;
  logic         en_a, clr_a, s_valid_a, s_ready_a, lrclk_a, sdata_a, underrun_a;
  logic [1:0]   mode_a;
  logic [47:0]  s_data_a;
  logic [2:0]   fifo_level_a;
  logic         en_b, clr_b, s_valid_b, s_ready_b, lrclk_b, sdata_b, underrun_b;
  logic [1:0]   mode_b;
  logic [127:0] s_data_b;
  logic [2:0]   fifo_level_b;

  logic [127:0] sb_a[$];
  logic [127:0] sb_b[$];
  int           n_checks;
  int           n_fail;
  logic [255:0] cap_lr, cap_sd, cap_ur;
  int           cap_lvl0;
  logic         prev_a, prev_b;

  always #5 sclk = ~sclk;

  i2s_tdm_tx #(.DATA_W(24), .SLOT_W(32), .NUM_CH(2), .FIFO_DEPTH(4)) u_dut_a (
    .sclk(sclk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .s_data(s_data_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .lrclk(lrclk_a), .sdata(sdata_a),
    .underrun(underrun_a), .clr_underrun(clr_a), .fifo_level(fifo_level_a)
  );

  i2s_tdm_tx #(.DATA_W(16), .SLOT_W(32), .NUM_CH(8), .FIFO_DEPTH(4)) u_dut_b (
    .sclk(sclk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .s_data(s_data_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .lrclk(lrclk_b), .sdata(sdata_b),
    .underrun(underrun_b), .clr_underrun(clr_b), .fifo_level(fifo_level_b)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic push(input int sel, input logic [127:0] d, input bit accept);
    step();
    if (sel == 0) begin
      s_valid_a = 1'b1;
      s_data_a  = d[47:0];
      check("s_ready_a", s_ready_a, accept);
      if (accept) sb_a.push_back({80'd0, d[47:0]});
    end else begin
      s_valid_b = 1'b1;
      s_data_b  = d;
      check("s_ready_b", s_ready_b, accept);
      if (accept) sb_b.push_back(d);
    end
    step();
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
  endtask

  // Record one frame of pins; optionally change mode, pulse clear or drop enable at given positions.
  task automatic capture(input int sel, input int chg_pos, input logic [1:0] chg_mode,
                         input int clr_pos, input int off_pos);
    int n;
    n = (sel == 0) ? c_NA : c_NB;
    cap_lr = '0;
    cap_sd = '0;
    cap_ur = '0;
    for (int i = 0; i < n; i++) begin
      step();
      cap_lr[i] = (sel == 0) ? lrclk_a : lrclk_b;
      cap_sd[i] = (sel == 0) ? sdata_a : sdata_b;
      cap_ur[i] = (sel == 0) ? underrun_a : underrun_b;
      if (i == 0) cap_lvl0 = (sel == 0) ? int'(fifo_level_a) : int'(fifo_level_b);
      if (sel == 0) begin
        clr_a = (i == clr_pos);
        if (i == chg_pos) mode_a = chg_mode;
        if (i == off_pos) en_a = 1'b0;
      end else begin
        clr_b = (i == clr_pos);
        if (i == chg_pos) mode_b = chg_mode;
        if (i == off_pos) en_b = 1'b0;
      end
    end
  endtask

  // Expected stream: concatenated MSB-first words with zero pad, delayed by one bit outside LJ.
  task automatic check_frame(input string tag, input int sel, input logic [1:0] md);
    logic [127:0] f;
    logic [255:0] st, e_lr, e_sd;
    int           n, nch, dw, k;
    logic         prev;
    f = '0;
    if (sel == 0) begin
      n = c_NA; nch = 2; dw = 24; prev = prev_a;
      if (sb_a.size() > 0) f = sb_a.pop_front();
    end else begin
      n = c_NB; nch = 8; dw = 16; prev = prev_b;
      if (sb_b.size() > 0) f = sb_b.pop_front();
    end
    st = '0;
    k  = 0;
    for (int c = 0; c < nch; c++) begin
      for (int i = dw - 1; i >= 0; i--) begin
        st[k] = f[c*dw + i];
        k++;
      end
      k += 32 - dw;
    end
    e_lr = '0;
    e_sd = '0;
    for (int p = 0; p < n; p++) begin
      if (md == c_LJ) begin
        e_lr[p] = (p < n / 2);
        e_sd[p] = st[p];
      end else begin
        e_lr[p] = (md == c_TDM) ? (p == 0) : (p >= n / 2);
        if (p == 0) e_sd[p] = prev;
        else        e_sd[p] = st[p-1];
      end
    end
    check({tag, ".lrclk"}, cap_lr, e_lr);
    check({tag, ".sdata"}, cap_sd, e_sd);
    if (sel == 0) prev_a = st[n-1];
    else          prev_b = st[n-1];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] fr;
    logic [15:0]  w;
    int           bad;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; prev_a = 1'b0; prev_b = 1'b0;
    en_a = 1'b0; clr_a = 1'b0; s_valid_a = 1'b0; mode_a = c_I2S; s_data_a = '0;
    en_b = 1'b0; clr_b = 1'b0; s_valid_b = 1'b0; mode_b = c_TDM; s_data_b = '0;
    repeat (3) step();
    check("rst.lrclk", lrclk_a, 1'b0);
    check("rst.sdata", sdata_a, 1'b0);
    check("rst.underrun", underrun_a, 1'b0);
    check("rst.level", fifo_level_a, 3'd0);
    check("rst.s_ready", s_ready_a, 1'b1);
    rst_n = 1'b1;
    step();

    // I2S then LJ with the same stereo frame; mid-frame mode changes must be ignored.
    fr = {80'd0, 24'h7FFFFE, 24'h800001};
    push(0, fr, 1'b1);
    push(0, fr, 1'b1);
    check("i2s.level_pre", fifo_level_a, 3'd2);
    en_a = 1'b1;
    capture(0, 10, c_LJ, -1, -1);
    check_frame("i2s", 0, c_I2S);
    check("i2s.lr0", cap_lr[0], 1'b0);
    check("i2s.lr31", cap_lr[31], 1'b0);
    check("i2s.lr32", cap_lr[32], 1'b1);
    check("i2s.sd1", cap_sd[1], 1'b1);
    check("i2s.sd2", cap_sd[2], 1'b0);
    check("i2s.sd24", cap_sd[24], 1'b1);
    check("i2s.sd25pad", cap_sd[25], 1'b0);
    check("i2s.sd33", cap_sd[33], 1'b0);
    check("i2s.sd34", cap_sd[34], 1'b1);
    check("i2s.sd56", cap_sd[56], 1'b0);
    check("i2s.level", cap_lvl0, 1);

    capture(0, 5, c_I2S, -1, -1);
    check_frame("lj", 0, c_LJ);
    check("lj.lr0", cap_lr[0], 1'b1);
    check("lj.lr31", cap_lr[31], 1'b1);
    check("lj.lr32", cap_lr[32], 1'b0);
    check("lj.sd0", cap_sd[0], 1'b1);
    check("lj.sd23", cap_sd[23], 1'b1);
    check("lj.sd24pad", cap_sd[24], 1'b0);
    check("lj.sd32", cap_sd[32], 1'b0);
    check("lj.sd33", cap_sd[33], 1'b1);
    check("lj.level", cap_lvl0, 0);
    check("lj.no_underrun", cap_ur[63], 1'b0);

    // Underrun frames, clear mid-frame, clear coincident with a new underrun.
    capture(0, -1, c_I2S, 20, -1);
    check_frame("und1", 0, c_I2S);
    check("und1.set", cap_ur[0], 1'b1);
    check("und1.before_clr", cap_ur[20], 1'b1);
    check("und1.cleared", cap_ur[21], 1'b0);
    capture(0, -1, c_I2S, c_NA - 1, -1);
    check_frame("und2", 0, c_I2S);
    check("und2.reset", cap_ur[0], 1'b1);
    capture(0, -1, c_I2S, -1, 10);
    check_frame("und3", 0, c_I2S);
    check("und3.set_wins", cap_ur[0], 1'b1);
    step();
    prev_a = 1'b0;

    // Fill while idle, reject a fifth frame, drain with level steps, then stop.
    check("fill.ur_sticky", underrun_a, 1'b1);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("fill.ur_clr", underrun_a, 1'b0);
    for (int k = 0; k < 5; k++) begin
      fr = '0;
      fr[31:0]  = $urandom();
      fr[47:32] = 16'($urandom());
      push(0, fr, k < 4);
      if (k == 3) check("fill.level4", fifo_level_a, 3'd4);
    end
    check("fill.level_after_reject", fifo_level_a, 3'd4);
    en_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      capture(0, -1, c_I2S, -1, (k == 3) ? 5 : -1);
      check_frame("drain", 0, c_I2S);
      check("drain.level", cap_lvl0, 3 - k);
    end
    step();
    check("stop.trail", sdata_a, prev_a);
    check("stop.lrclk", lrclk_a, 1'b0);
    prev_a = 1'b0;
    en_a = 1'b1;
    bad = 0;
    for (int i = 0; i < c_NA + 4; i++) begin
      step();
      if (lrclk_a || sdata_a || underrun_a || fifo_level_a != 3'd0) bad++;
    end
    check("reenable.idle", bad, 0);

    // Asynchronous reset mid-slot flushes the FIFO; next frame starts cleanly.
    en_a = 1'b0;
    push(0, {80'd0, 24'hFFFFFF, 24'h123456}, 1'b1);
    push(0, {80'd0, 24'h0F0F0F, 24'hF0F0F0}, 1'b1);
    en_a = 1'b1;
    repeat (41) step();
    check("rst_mid.lr_pre", lrclk_a, 1'b1);
    check("rst_mid.sd_pre", sdata_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.lrclk", lrclk_a, 1'b0);
    check("rst_mid.sdata", sdata_a, 1'b0);
    check("rst_mid.level", fifo_level_a, 3'd0);
    sb_a.delete();
    prev_a = 1'b0;
    step();
    rst_n = 1'b1;
    push(0, {80'd0, 24'hABCDEF, 24'h5A5A5A}, 1'b1);
    capture(0, -1, c_I2S, -1, 5);
    check_frame("post_rst", 0, c_I2S);
    check("post_rst.level", cap_lvl0, 0);
    step();

    // TDM, 8 slots of 16-bit words in 32-bit slots.
    fr = '0;
    for (int c = 0; c < 8; c++) fr[c*16 +: 16] = 16'h1000 + 16'(c);
    push(1, fr, 1'b1);
    en_b = 1'b1;
    capture(1, -1, c_TDM, -1, -1);
    check_frame("tdm", 1, c_TDM);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 16; i++) w[15-i] = cap_sd[32*c + 1 + i];
      check("tdm.slot", w, 16'h1000 + 16'(c));
    end
    capture(1, -1, c_TDM, -1, 10);
    check_frame("tdm.und", 1, c_TDM);
    check("tdm.und.set", cap_ur[0], 1'b1);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
